// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg_pkg
// Description : Shared constants for the decode/execute pipeline: ALU command
//               codes, decode mode/opcode encodings, status-register bit
//               positions, and the ID/EX control-word type.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_reg_pkg;

    // ALU command codes; memory ops reuse the adder for address generation
    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_MVN = 4'b1001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_CMP = 4'b0100;
    localparam logic [3:0] EX_TST = 4'b0110;
    localparam logic [3:0] EX_LDR = 4'b0010;
    localparam logic [3:0] EX_STR = 4'b0010;

    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r;
        logic       mem_w;
        logic       b;
        logic       s;
        logic [3:0] ex_cmd;
    } ctrl_t;

    // A bubble carries no side effects, so every control bit is dropped
    function automatic ctrl_t gate_bubble(input ctrl_t c);
        return c.valid ? c : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Async-reset register with synchronous clear (priority) and
//               load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with freeze, flush and valid bit.
//               Define FORWARDING_EN to carry src1/src2 indices for forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          freeze,
    input  logic          valid_in,
    input  logic          WB_EN_in,
    input  logic          MEM_R_in,
    input  logic          MEM_W_in,
    input  logic          B_in,
    input  logic          S_in,
    input  logic [3:0]    EX_CMD_in,
    input  logic [DW-1:0] PC_in,
    input  logic [DW-1:0] Val_Rn_in,
    input  logic [DW-1:0] Val_Rm_in,
    input  logic          imm_in,
    input  logic [11:0]   Shift_operand_in,
    input  logic [23:0]   Signed_imm_24_in,
    input  logic [RW-1:0] Dest_in,
    input  logic [3:0]    SR_in,
`ifdef FORWARDING_EN
    input  logic [RW-1:0] src1_in,
    input  logic [RW-1:0] src2_in,
    output logic [RW-1:0] src1_out,
    output logic [RW-1:0] src2_out,
`endif
    output logic          WB_EN_out,
    output logic          MEM_R_out,
    output logic          MEM_W_out,
    output logic          B_out,
    output logic          S_out,
    output logic [3:0]    EX_CMD_out,
    output logic [DW-1:0] PC_out,
    output logic [DW-1:0] Val_Rn_out,
    output logic [DW-1:0] Val_Rm_out,
    output logic          imm_out,
    output logic [11:0]   Shift_operand_out,
    output logic [23:0]   Signed_imm_24_out,
    output logic [RW-1:0] Dest_out,
    output logic [3:0]    SR_out,
    output logic          valid_out
);

    localparam int c_CTW = $bits(ctrl_t);
    localparam int c_DPW = 3*DW + 1 + 12 + 24 + RW + 4;

    ctrl_t w_ctrl_raw;
    ctrl_t w_ctrl_gated;
    ctrl_t w_ctrl_q;
    logic  w_en;

    assign w_en = ~freeze;

    assign w_ctrl_raw = '{valid:  valid_in,
                          wb_en:  WB_EN_in,
                          mem_r:  MEM_R_in,
                          mem_w:  MEM_W_in,
                          b:      B_in,
                          s:      S_in,
                          ex_cmd: EX_CMD_in};
    assign w_ctrl_gated = gate_bubble(w_ctrl_raw);

    // Source indices ride with the control group so a flush clears them too
`ifdef FORWARDING_EN
    localparam int c_CGW = c_CTW + 2*RW;
    logic [c_CGW-1:0] w_cg_d;
    logic [c_CGW-1:0] w_cg_q;
    assign w_cg_d = {w_ctrl_gated, src1_in, src2_in};
    assign {w_ctrl_q, src1_out, src2_out} = w_cg_q;
`else
    localparam int c_CGW = c_CTW;
    logic [c_CGW-1:0] w_cg_d;
    logic [c_CGW-1:0] w_cg_q;
    assign w_cg_d   = w_ctrl_gated;
    assign w_ctrl_q = w_cg_q;
`endif

    pipe_reg #(.W(c_CGW)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   (w_cg_d),
        .q   (w_cg_q)
    );

    logic [c_DPW-1:0] w_dp_d;
    logic [c_DPW-1:0] w_dp_q;

    assign w_dp_d = {PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
                     Signed_imm_24_in, Dest_in, SR_in};
    assign {PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
            Signed_imm_24_out, Dest_out, SR_out} = w_dp_q;

    // Datapath contents behind a bubble are never consumed, so no clear
    pipe_reg #(.W(c_DPW)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (1'b0),
        .d   (w_dp_d),
        .q   (w_dp_q)
    );

    assign valid_out  = w_ctrl_q.valid;
    assign WB_EN_out  = w_ctrl_q.wb_en;
    assign MEM_R_out  = w_ctrl_q.mem_r;
    assign MEM_W_out  = w_ctrl_q.mem_w;
    assign B_out      = w_ctrl_q.b;
    assign S_out      = w_ctrl_q.s;
    assign EX_CMD_out = w_ctrl_q.ex_cmd;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Self-checking bench for id_ex_stage_reg (optionally built
//               with FORWARDING_EN) against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int DPW = 3*DW + 1 + 12 + 24 + RW + 4;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_STR = 4'b0010;

    logic clk = 1'b0;
    logic rst, flush, freeze, valid_in;
    logic WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in;
    logic [3:0]    EX_CMD_in;
    logic [DW-1:0] PC_in, Val_Rn_in, Val_Rm_in;
    logic          imm_in;
    logic [11:0]   Shift_operand_in;
    logic [23:0]   Signed_imm_24_in;
    logic [RW-1:0] Dest_in, src1_in, src2_in;
    logic [3:0]    SR_in;

    logic WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out, valid_out;
    logic [3:0]    EX_CMD_out;
    logic [DW-1:0] PC_out, Val_Rn_out, Val_Rm_out;
    logic          imm_out;
    logic [11:0]   Shift_operand_out;
    logic [23:0]   Signed_imm_24_out;
    logic [RW-1:0] Dest_out, src1_out, src2_out;
    logic [3:0]    SR_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what EX should hold after each edge
    logic [9:0]      e_ctrl;
    logic [DPW-1:0]  e_dp;
    logic [2*RW-1:0] e_src;
    bit              dp_known;

    logic [9:0]      obs_ctrl;
    logic [DPW-1:0]  obs_dp;
    logic [2*RW-1:0] obs_src;

    assign obs_ctrl = {valid_out, WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out, EX_CMD_out};
    assign obs_dp   = {PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
                       Signed_imm_24_out, Dest_out, SR_out};
`ifdef FORWARDING_EN
    assign obs_src  = {src1_out, src2_out};
`else
    assign obs_src  = '0;
    assign src1_out = '0;
    assign src2_out = '0;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(DW), .RW(RW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .freeze            (freeze),
        .valid_in          (valid_in),
        .WB_EN_in          (WB_EN_in),
        .MEM_R_in          (MEM_R_in),
        .MEM_W_in          (MEM_W_in),
        .B_in              (B_in),
        .S_in              (S_in),
        .EX_CMD_in         (EX_CMD_in),
        .PC_in             (PC_in),
        .Val_Rn_in         (Val_Rn_in),
        .Val_Rm_in         (Val_Rm_in),
        .imm_in            (imm_in),
        .Shift_operand_in  (Shift_operand_in),
        .Signed_imm_24_in  (Signed_imm_24_in),
        .Dest_in           (Dest_in),
        .SR_in             (SR_in),
`ifdef FORWARDING_EN
        .src1_in           (src1_in),
        .src2_in           (src2_in),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
`endif
        .WB_EN_out         (WB_EN_out),
        .MEM_R_out         (MEM_R_out),
        .MEM_W_out         (MEM_W_out),
        .B_out             (B_out),
        .S_out             (S_out),
        .EX_CMD_out        (EX_CMD_out),
        .PC_out            (PC_out),
        .Val_Rn_out        (Val_Rn_out),
        .Val_Rm_out        (Val_Rm_out),
        .imm_out           (imm_out),
        .Shift_operand_out (Shift_operand_out),
        .Signed_imm_24_out (Signed_imm_24_out),
        .Dest_out          (Dest_out),
        .SR_out            (SR_out),
        .valid_out         (valid_out)
    );

    // Rule-level model of one rising edge: rst > flush > freeze > load
    task automatic model_edge();
        if (rst) begin
            e_ctrl = '0; e_dp = '0; e_src = '0; dp_known = 1'b1;
        end else if (flush) begin
            e_ctrl = '0; e_src = '0; dp_known = 1'b0;
        end else if (!freeze) begin
            if (valid_in)
                e_ctrl = {1'b1, WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in, EX_CMD_in};
            else
                e_ctrl = '0;
            e_dp = {PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
                    Signed_imm_24_in, Dest_in, SR_in};
            dp_known = 1'b1;
`ifdef FORWARDING_EN
            e_src = {src1_in, src2_in};
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_random();
        valid_in         = 1'($urandom);
        WB_EN_in         = 1'($urandom);
        MEM_R_in         = 1'($urandom);
        MEM_W_in         = 1'($urandom);
        B_in             = 1'($urandom);
        S_in             = 1'($urandom);
        EX_CMD_in        = 4'($urandom);
        PC_in            = $urandom;
        Val_Rn_in        = $urandom;
        Val_Rm_in        = $urandom;
        imm_in           = 1'($urandom);
        Shift_operand_in = 12'($urandom);
        Signed_imm_24_in = 24'($urandom);
        Dest_in          = RW'($urandom);
        SR_in            = 4'($urandom);
        src1_in          = RW'($urandom);
        src2_in          = RW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        drive_random();
        #1 rst = 1'b1;
        model_edge();
        #2;
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL reset_initial: got ctrl=%h dp=%h want all zero", obs_ctrl, obs_dp);
        end
        @(negedge clk) rst = 1'b0;
        drive_random();
        valid_in = 1'b1; WB_EN_in = 1'b1; PC_in = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL reset_preload: got ctrl=%h dp=%h want ctrl=%h dp=%h", obs_ctrl, obs_dp, e_ctrl, e_dp);
        end
        // Assert reset mid-cycle while stalled; clearing must not wait for clk
        freeze = 1'b1;
        #2 rst = 1'b1;
        model_edge();
        #1;
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== '0) begin
            n_errors++;
            $display("FAIL reset_async: got ctrl=%h dp=%h src=%h want all zero", obs_ctrl, obs_dp, obs_src);
        end
        tick();
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== '0) begin
            n_errors++;
            $display("FAIL reset_release_stall: got ctrl=%h dp=%h want bubble", obs_ctrl, obs_dp);
        end
        freeze = 1'b0;
        drive_random();
        valid_in = 1'b1;
        tick();
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL reset_first_load: got ctrl=%h dp=%h want ctrl=%h dp=%h", obs_ctrl, obs_dp, e_ctrl, e_dp);
        end
    endtask

    task automatic test_load_add();
        drive_random();
        valid_in = 1'b1; WB_EN_in = 1'b1; MEM_R_in = 1'b0; MEM_W_in = 1'b0;
        B_in = 1'b0; S_in = 1'b0; EX_CMD_in = C_ADD;
        Val_Rn_in = 32'h10; Val_Rm_in = 32'h20; Dest_in = 4'd3;
        tick();
        n_checks++;
        if ({valid_out, WB_EN_out, EX_CMD_out, Val_Rn_out, Val_Rm_out, Dest_out} !==
            {1'b1, 1'b1, C_ADD, 32'h10, 32'h20, 4'd3}) begin
            n_errors++;
            $display("FAIL load_add: got v=%b wb=%b cmd=%h rn=%h rm=%h d=%h want 1 1 2 10 20 3",
                     valid_out, WB_EN_out, EX_CMD_out, Val_Rn_out, Val_Rm_out, Dest_out);
        end
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL load_add_all: got ctrl=%h dp=%h want ctrl=%h dp=%h", obs_ctrl, obs_dp, e_ctrl, e_dp);
        end
    endtask

    task automatic test_freeze();
        logic [9:0]     held_ctrl;
        logic [DPW-1:0] held_dp;
        drive_random();
        valid_in = 1'b1;
        tick();
        held_ctrl = e_ctrl;
        held_dp   = e_dp;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
            n_checks++;
            if ({obs_ctrl, obs_dp} !== {held_ctrl, held_dp}) begin
                n_errors++;
                $display("FAIL freeze_hold[%0d]: got ctrl=%h dp=%h want ctrl=%h dp=%h",
                         i, obs_ctrl, obs_dp, held_ctrl, held_dp);
            end
        end
        freeze = 1'b0;
        drive_random();
        valid_in = 1'b1;
        tick();
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL freeze_release: got ctrl=%h dp=%h want ctrl=%h dp=%h", obs_ctrl, obs_dp, e_ctrl, e_dp);
        end
    endtask

    task automatic test_flush_freeze();
        drive_random();
        valid_in = 1'b1; MEM_W_in = 1'b1; WB_EN_in = 1'b0; EX_CMD_in = C_STR;
        tick();
        n_checks++;
        if ({valid_out, MEM_W_out, EX_CMD_out} !== {1'b1, 1'b1, C_STR}) begin
            n_errors++;
            $display("FAIL load_str: got v=%b memw=%b cmd=%h want 1 1 %h", valid_out, MEM_W_out, EX_CMD_out, C_STR);
        end
        drive_random();
        valid_in = 1'b1; MEM_W_in = 1'b1;
        flush = 1'b1; freeze = 1'b1;
        tick();
        flush = 1'b0; freeze = 1'b0;
        n_checks++;
        if ({valid_out, MEM_W_out} !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_over_freeze: got v=%b memw=%b want 0 0", valid_out, MEM_W_out);
        end
        n_checks++;
        if ({obs_ctrl, obs_src} !== {e_ctrl, e_src}) begin
            n_errors++;
            $display("FAIL flush_ctrl: got ctrl=%h src=%h want ctrl=%h src=%h", obs_ctrl, obs_src, e_ctrl, e_src);
        end
    endtask

    task automatic test_bubble();
        drive_random();
        valid_in = 1'b0; WB_EN_in = 1'b1; MEM_R_in = 1'b1;
        tick();
        n_checks++;
        if ({WB_EN_out, MEM_R_out, valid_out} !== 3'b000) begin
            n_errors++;
            $display("FAIL bubble_gate: got wb=%b memr=%b v=%b want 0 0 0", WB_EN_out, MEM_R_out, valid_out);
        end
        n_checks++;
        if ({obs_ctrl, obs_dp, obs_src} !== {e_ctrl, e_dp, e_src}) begin
            n_errors++;
            $display("FAIL bubble_all: got ctrl=%h dp=%h want ctrl=%h dp=%h", obs_ctrl, obs_dp, e_ctrl, e_dp);
        end
    endtask

`ifdef FORWARDING_EN
    task automatic test_forwarding();
        drive_random();
        valid_in = 1'b1; src1_in = 4'd5; src2_in = 4'd7;
        tick();
        n_checks++;
        if ({src1_out, src2_out} !== {4'd5, 4'd7}) begin
            n_errors++;
            $display("FAIL fwd_load: got src1=%h src2=%h want 5 7", src1_out, src2_out);
        end
        drive_random();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({src1_out, src2_out} !== 8'h00) begin
            n_errors++;
            $display("FAIL fwd_flush: got src1=%h src2=%h want 0 0", src1_out, src2_out);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_random();
            flush  = ($urandom_range(0, 5) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if ({obs_ctrl, obs_src} !== {e_ctrl, e_src}) begin
                n_errors++;
                $display("FAIL rand_ctrl[%0d]: got ctrl=%h src=%h want ctrl=%h src=%h",
                         i, obs_ctrl, obs_src, e_ctrl, e_src);
            end
            if (dp_known) begin
                n_checks++;
                if (obs_dp !== e_dp) begin
                    n_errors++;
                    $display("FAIL rand_dp[%0d]: got %h want %h", i, obs_dp, e_dp);
                end
            end
            if (valid_out !== 1'b1) begin
                n_checks++;
                if ({WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out} !== 5'b0) begin
                    n_errors++;
                    $display("FAIL rand_invariant[%0d]: got ctrl bits %b want 00000 with valid_out=%b",
                             i, {WB_EN_out, MEM_R_out, MEM_W_out, B_out, S_out}, valid_out);
                end
            end
        end
        flush = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        e_ctrl = '0; e_dp = '0; e_src = '0; dp_known = 1'b1;
        test_reset();
        test_load_add();
        test_freeze();
        test_flush_freeze();
        test_bubble();
`ifdef FORWARDING_EN
        test_forwarding();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
